// File: rtl/bus_if.sv
// rtl/bus_if.sv - peripheral bus signal bundle shared by initiators and responders
interface bus_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        gnt;
    logic        rvalid;
    logic [31:0] rdata;
    logic        err;

    modport master (
        output req, we, addr, wdata,
        input  gnt, rvalid, rdata, err
    );

    modport slave (
        input  req, we, addr, wdata,
        output gnt, rvalid, rdata, err
    );
endinterface

// File: rtl/bus_cmd_master.sv
// rtl/bus_cmd_master.sv - single-outstanding command initiator for bus_if
module bus_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 16
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        cmd_valid_i,
    output logic        cmd_ready_o,
    input  logic        cmd_we_i,
    input  logic [31:0] cmd_addr_i,
    input  logic [31:0] cmd_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o,
    output logic        rsp_timeout_o,
    output logic        busy_o,
    bus_if.master       bus
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_REQ  = 2'd1;
    localparam logic [1:0] ST_WAIT = 2'd2;
    localparam logic [1:0] ST_RESP = 2'd3;

    // Counter value seen during the TIMEOUT_CYCLES-th REQ/WAIT cycle.
    localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYCLES - 1);

    logic [1:0]  state_q, state_d;
    logic        we_q, we_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [7:0]  cnt_q, cnt_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;
    logic        tout_q, tout_d;
    logic        expired;
    logic        req;

    assign req           = (state_q == ST_REQ);
    assign cmd_ready_o   = (state_q == ST_IDLE) && rst_ni;
    assign busy_o        = (state_q != ST_IDLE);
    assign rsp_valid_o   = (state_q == ST_RESP);
    assign rsp_rdata_o   = rdata_q;
    assign rsp_err_o     = err_q;
    assign rsp_timeout_o = tout_q;

    // Address/data lines are zeroed whenever no request is on the bus.
    assign bus.req   = req;
    assign bus.we    = req ? we_q : 1'b0;
    assign bus.addr  = req ? addr_q : 32'h0;
    assign bus.wdata = req ? wdata_q : 32'h0;

    // Next-state, command latch, timeout counter and response capture.
    always_comb begin
        state_d = state_q;
        we_d    = we_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        cnt_d   = cnt_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        tout_d  = tout_q;
        // ">=" rather than "==": a grant on the last allowed cycle moves to
        // WAIT with the counter already past the limit, so WAIT then expires
        // on its first cycle unless rvalid is there.
        expired = (cnt_q >= TO_LAST);
        case (state_q)
            ST_IDLE: begin
                if (cmd_valid_i && cmd_ready_o) begin
                    we_d    = cmd_we_i;
                    addr_d  = cmd_addr_i;
                    wdata_d = cmd_wdata_i;
                    cnt_d   = 8'd0;
                    state_d = ST_REQ;
                end
            end
            ST_REQ: begin
                cnt_d = cnt_q + 8'd1;
                if (bus.gnt) begin
                    state_d = ST_WAIT;
                end else if (expired) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    tout_d  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_WAIT: begin
                cnt_d = cnt_q + 8'd1;
                if (bus.rvalid) begin
                    rdata_d = we_q ? 32'h0 : bus.rdata;
                    err_d   = bus.err;
                    tout_d  = 1'b0;
                    state_d = ST_RESP;
                end else if (expired) begin
                    rdata_d = 32'h0;
                    err_d   = 1'b0;
                    tout_d  = 1'b1;
                    state_d = ST_RESP;
                end
            end
            ST_RESP: begin
                if (rsp_ready_i) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous active-low reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            addr_q  <= 32'h0;
            wdata_q <= 32'h0;
            cnt_q   <= 8'd0;
            rdata_q <= 32'h0;
            err_q   <= 1'b0;
            tout_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            cnt_q   <= cnt_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            tout_q  <= tout_d;
        end
    end

endmodule

// File: tb/tb_bus_cmd_master.sv
// tb/tb_bus_cmd_master.sv - randomized model-checked bench for bus_cmd_master
module tb_bus_cmd_master;
    localparam int T1 = 16;
    localparam int T2 = 4;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    logic        cmd_valid, cmd_ready, cmd_we, rsp_valid, rsp_ready, rsp_err, rsp_timeout, busy;
    logic [31:0] cmd_addr, cmd_wdata, rsp_rdata;
    logic        cmd2_valid, cmd2_ready, cmd2_we, rsp2_valid, rsp2_ready, rsp2_err, rsp2_timeout, busy2;
    logic [31:0] cmd2_addr, cmd2_wdata, rsp2_rdata;

    bus_if bus_m ();
    bus_if bus_t ();

    bus_cmd_master #(.TIMEOUT_CYCLES(T1)) dut (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmd_valid_i(cmd_valid), .cmd_ready_o(cmd_ready), .cmd_we_i(cmd_we),
        .cmd_addr_i(cmd_addr), .cmd_wdata_i(cmd_wdata),
        .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_rdata_o(rsp_rdata),
        .rsp_err_o(rsp_err), .rsp_timeout_o(rsp_timeout), .busy_o(busy),
        .bus(bus_m)
    );

    bus_cmd_master #(.TIMEOUT_CYCLES(T2)) dut_to (
        .clk_i(clk), .rst_ni(rst_ni),
        .cmd_valid_i(cmd2_valid), .cmd_ready_o(cmd2_ready), .cmd_we_i(cmd2_we),
        .cmd_addr_i(cmd2_addr), .cmd_wdata_i(cmd2_wdata),
        .rsp_valid_o(rsp2_valid), .rsp_ready_i(rsp2_ready), .rsp_rdata_o(rsp2_rdata),
        .rsp_err_o(rsp2_err), .rsp_timeout_o(rsp2_timeout), .busy_o(busy2),
        .bus(bus_t)
    );

    int checks = 0;
    int errors = 0;

    // Reference model of the current transaction (written by the driver).
    int          issued = 0;
    int          m_n = 0, m_r = 0, m_req_last = 0;
    logic        m_we = 1'b0, m_err = 1'b0, m_to = 1'b0;
    logic [31:0] m_addr = 32'h0, m_wdata = 32'h0, m_rdata = 32'h0;

    // Responder schedule (written by the driver).
    bit          rs_on = 1'b0;
    int          rs_n = 0, rs_kg = 0, rs_kr = 0, rs_end = 0;
    logic [31:0] rs_data = 32'h0;
    logic        rs_err = 1'b0;
    int          rdy_mode = 1;

    // Owned by the compare process.
    int          done_cnt = 0;
    int          obs_lat = -1, obs_rise = 0, obs_hs = 0;
    logic [31:0] obs_rdata = 32'h0;
    logic        obs_err = 1'b0, obs_to = 1'b0;
    bit          rv_prev = 1'b0, rst_prev_low = 1'b0;

    task automatic chk1(input string name, input logic got, input logic exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    task automatic chk32(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Compare process: every cycle, DUT outputs against the model's schedule.
    initial begin
        bit a, e_busy, e_req, e_rv;
        forever begin
            @(negedge clk);
            if (!rst_ni) begin
                chk1("rst_cmd_ready", cmd_ready, 1'b0);
                if (rst_prev_low) begin
                    chk1("rst_req", bus_m.req, 1'b0);
                    chk1("rst_rsp_valid", rsp_valid, 1'b0);
                    chk1("rst_busy", busy, 1'b0);
                end
                done_cnt = issued;
                rst_prev_low = 1'b1;
            end else begin
                rst_prev_low = 1'b0;
                a      = (issued != done_cnt);
                e_busy = a && (cyc > m_n);
                e_req  = e_busy && (cyc <= m_n + m_req_last);
                e_rv   = a && (cyc >= m_r);
                chk1("busy", busy, e_busy);
                chk1("cmd_ready", cmd_ready, !e_busy);
                chk1("req", bus_m.req, e_req);
                chk1("rsp_valid", rsp_valid, e_rv);
                chk1("bus_we", bus_m.we, e_req ? m_we : 1'b0);
                chk32("bus_addr", bus_m.addr, e_req ? m_addr : 32'h0);
                chk32("bus_wdata", bus_m.wdata, e_req ? m_wdata : 32'h0);
                if (e_rv) begin
                    chk32("rsp_rdata", rsp_rdata, m_rdata);
                    chk1("rsp_err", rsp_err, m_err);
                    chk1("rsp_timeout", rsp_timeout, m_to);
                    if (rsp_ready) done_cnt++;
                end
            end
            if (rsp_valid && !rv_prev) begin
                obs_lat   = cyc - m_n;
                obs_rise  = cyc;
                obs_rdata = rsp_rdata;
                obs_err   = rsp_err;
                obs_to    = rsp_timeout;
            end
            if (rsp_valid && rsp_ready) obs_hs = cyc;
            rv_prev = rsp_valid;
        end
    end

    // Responder for the main DUT: scheduled events inside a transaction
    // window, random noise on gnt/rvalid/err/rdata everywhere else.
    initial begin
        bit in_win;
        bus_m.gnt = 1'b0; bus_m.rvalid = 1'b0; bus_m.err = 1'b0; bus_m.rdata = 32'h0;
        rsp_ready = 1'b0;
        forever begin
            @(posedge clk);
            #1;
            in_win = rs_on && (cyc > rs_n) && (cyc <= rs_end);
            if (in_win) begin
                bus_m.gnt    = (cyc == rs_n + rs_kg);
                bus_m.rvalid = (cyc == rs_n + rs_kr);
                bus_m.err    = bus_m.rvalid ? rs_err : 1'($urandom_range(0, 1));
                bus_m.rdata  = bus_m.rvalid ? rs_data : $urandom;
            end else begin
                bus_m.gnt    = ($urandom_range(0, 3) == 0);
                bus_m.rvalid = ($urandom_range(0, 3) == 0);
                bus_m.err    = 1'($urandom_range(0, 1));
                bus_m.rdata  = $urandom;
            end
            case (rdy_mode)
                0:       rsp_ready = ($urandom_range(0, 2) != 0);
                1:       rsp_ready = 1'b1;
                default: rsp_ready = (cyc >= m_r + 5);
            endcase
        end
    end

    task automatic issue_tx(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                            input logic [31:0] rdat, input int g, input int r, input logic e);
        int guard, kg, kr, lim, fin;
        guard = 0;
        while (((issued != done_cnt) || (cyc <= rs_end)) && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
            cmd_valid = (issued != done_cnt) && ($urandom_range(0, 3) == 0);
            cmd_we    = 1'($urandom_range(0, 1));
            cmd_addr  = $urandom;
            cmd_wdata = $urandom;
        end
        if (guard >= 300) begin
            checks++;
            errors++;
            $display("FAIL issue_wait: DUT still busy after %0d cycles", guard);
        end
        kg = g + 1;
        kr = kg + r;
        if (kg > T1) begin
            m_to = 1'b1; m_req_last = T1; fin = T1;
        end else begin
            lim = (kg + 1 > T1) ? kg + 1 : T1;
            m_req_last = kg;
            if (kr <= lim) begin
                m_to = 1'b0; fin = kr;
            end else begin
                m_to = 1'b1; fin = lim;
            end
        end
        m_n = cyc; m_r = cyc + fin + 1;
        m_we = we; m_addr = addr; m_wdata = wdata;
        m_err   = m_to ? 1'b0 : e;
        m_rdata = (m_to || we) ? 32'h0 : rdat;
        rs_n = cyc; rs_kg = kg; rs_kr = kr; rs_end = cyc + kr;
        rs_data = rdat; rs_err = e; rs_on = 1'b1;
        issued++;
        cmd_valid = 1'b1; cmd_we = we; cmd_addr = addr; cmd_wdata = wdata;
        @(posedge clk);
        #1;
        cmd_valid = 1'b0;
    endtask

    task automatic wait_done();
        int guard;
        guard = 0;
        while ((issued != done_cnt) && guard < 300) begin
            @(posedge clk);
            #1;
            guard++;
        end
        if (issued != done_cnt) begin
            checks++;
            errors++;
            $display("FAIL wait_done: no response handshake within %0d cycles", guard);
        end
    endtask

    // TIMEOUT_CYCLES=4 instance: no grant ever, late rvalid afterwards.
    task automatic run_timeout();
        int n, vcnt, first;
        logic to_s, err_s;
        logic [31:0] rd_s;
        bit e_req;
        vcnt = 0; first = -1; to_s = 1'b0; err_s = 1'b1; rd_s = 32'hFFFF_FFFF;
        n = cyc;
        cmd2_valid = 1'b1; cmd2_we = 1'b1; cmd2_addr = 32'h1000_0010; cmd2_wdata = 32'h0000_CAFE;
        for (int k = 0; k < 14; k++) begin
            @(posedge clk);
            #1;
            cmd2_valid   = 1'b0;
            bus_t.rvalid = (cyc == n + 7);
            bus_t.err    = (cyc == n + 7);
            bus_t.rdata  = $urandom;
            @(negedge clk);
            e_req = (cyc >= n + 1) && (cyc <= n + 4);
            chk1("to_req", bus_t.req, e_req);
            chk1("to_we", bus_t.we, e_req);
            chk32("to_addr", bus_t.addr, e_req ? 32'h1000_0010 : 32'h0);
            chk32("to_wdata", bus_t.wdata, e_req ? 32'h0000_CAFE : 32'h0);
            chk1("to_busy", busy2, (cyc >= n + 1) && (cyc <= n + 5));
            if (rsp2_valid) begin
                vcnt++;
                if (first < 0) begin
                    first = cyc; to_s = rsp2_timeout; err_s = rsp2_err; rd_s = rsp2_rdata;
                end
            end
        end
        @(posedge clk);
        #1;
        bus_t.rvalid = 1'b0;
        chk32("to_latency", 32'(first - n), 32'd5);
        chk32("to_valid_cycles", 32'(vcnt), 32'd1);
        chk1("to_flag", to_s, 1'b1);
        chk1("to_err", err_s, 1'b0);
        chk32("to_rdata", rd_s, 32'h0);
    endtask

    task automatic run_boundaries();
        int gt[6] = '{14, 15, 15, 16, 0, 0};
        int rt[6] = '{1, 1, 2, 1, 15, 16};
        int lt[6] = '{17, 18, 18, 17, 17, 17};
        bit tt[6] = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        rdy_mode = 1;
        for (int i = 0; i < 6; i++) begin
            issue_tx(1'b0, 32'h0000_0100 + 32'(i * 4), 32'h0, 32'hB000_0000 + 32'(i), gt[i], rt[i], 1'b0);
            wait_done();
            chk32("bnd_latency", 32'(obs_lat), 32'(lt[i]));
            chk1("bnd_timeout", obs_to, tt[i]);
        end
    endtask

    task automatic run_random(input int count);
        int g, r;
        rdy_mode = 0;
        for (int i = 0; i < count; i++) begin
            g = ($urandom_range(0, 7) == 0) ? int'($urandom_range(0, 18)) : int'($urandom_range(0, 3));
            r = ($urandom_range(0, 7) == 0) ? int'($urandom_range(1, 18)) : int'($urandom_range(1, 3));
            issue_tx(1'($urandom_range(0, 1)), $urandom, $urandom, $urandom, g, r, 1'($urandom_range(0, 1)));
        end
        wait_done();
    endtask

    initial begin
        cmd_valid = 1'b0; cmd_we = 1'b0; cmd_addr = 32'h0; cmd_wdata = 32'h0;
        cmd2_valid = 1'b0; cmd2_we = 1'b0; cmd2_addr = 32'h0; cmd2_wdata = 32'h0;
        rsp2_ready = 1'b1;
        bus_t.gnt = 1'b0; bus_t.rvalid = 1'b0; bus_t.err = 1'b0; bus_t.rdata = 32'h0;
        rdy_mode = 1;
        repeat (3) @(posedge clk);
        #1;
        rst_ni = 1'b1;

        issue_tx(1'b1, 32'h0, 32'h0000_0005, 32'h7777_7777, 0, 1, 1'b0);
        wait_done();
        chk32("wr_latency", 32'(obs_lat), 32'd3);
        chk32("wr_rdata", obs_rdata, 32'h0);
        chk1("wr_err", obs_err, 1'b0);

        issue_tx(1'b0, 32'h0, 32'h1234_5678, 32'h0000_0005, 0, 1, 1'b0);
        wait_done();
        chk32("rd_latency", 32'(obs_lat), 32'd3);
        chk32("rd_rdata", obs_rdata, 32'h0000_0005);

        issue_tx(1'b0, 32'h0000_0020, 32'h0, 32'hDEAD_BEEF, 2, 3, 1'b0);
        wait_done();
        chk32("ws_latency", 32'(obs_lat), 32'd7);
        chk32("ws_rdata", obs_rdata, 32'hDEAD_BEEF);

        rdy_mode = 2;
        issue_tx(1'b0, 32'h0000_0024, 32'h0, 32'h1357_9BDF, 0, 1, 1'b1);
        wait_done();
        chk1("bp_err", obs_err, 1'b1);
        chk32("bp_hold", 32'(obs_hs - obs_rise), 32'd5);
        rdy_mode = 1;

        run_timeout();

        issue_tx(1'b0, 32'h0000_0040, 32'h0, 32'h0000_1234, 0, 5, 1'b0);
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        rst_ni = 1'b0;
        @(posedge clk);
        #1;
        rst_ni = 1'b1;
        issue_tx(1'b0, 32'h0000_0044, 32'h0, 32'h0000_A5A5, 1, 1, 1'b0);
        wait_done();
        chk32("post_rst_latency", 32'(obs_lat), 32'd4);
        chk32("post_rst_rdata", obs_rdata, 32'h0000_A5A5);

        run_boundaries();
        run_random(80);

        repeat (4) @(posedge clk);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not finish in time");
        $display("Simulation finished: %0d checks, %0d errors", checks, errors + 1);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/bus_cmd_master.md
# bus_cmd_master

Single-transaction initiator for the `bus_if` peripheral bus. It accepts one read or write command at a time on a valid/ready command port and drives it onto `bus_if.master`. It waits for grant and read-valid, then returns read data and status on a valid/ready response port. It lets testbenches, boot sequencers and accelerator control logic reach memory-mapped peripherals (GPO, timers, etc.) without embedding the bus protocol themselves.

## Interface
- `TIMEOUT_CYCLES`, default 16: maximum cycles spent in REQ+WAIT before the transaction is abandoned. Legal range 2..255.
- `clk_i`  in  1  clock; all logic updates on the rising edge.
- `rst_ni`  in  1  synchronous, active-low reset.
- `cmd_valid_i`  in  1  command present.
- `cmd_ready_o`  out  1  command accepted when high together with `cmd_valid_i`.
- `cmd_we_i`  in  1  1 = write, 0 = read.
- `cmd_addr_i`  in  32  target byte address.
- `cmd_wdata_i`  in  32  write data; ignored for reads.
- `rsp_valid_o`  out  1  response present.
- `rsp_ready_i`  in  1  response consumed when high together with `rsp_valid_o`.
- `rsp_rdata_o`  out  32  read data. Forced to 0 for writes and for timeouts.
- `rsp_err_o`  out  1  responder returned `err`, sampled with `rvalid`.
- `rsp_timeout_o`  out  1  transaction abandoned after `TIMEOUT_CYCLES`.
- `busy_o`  out  1  high in any state except IDLE.
- `bus`  `bus_if.master`  —  drives `req`, `we`, `addr[31:0]`, `wdata[31:0]`; samples `gnt`, `rvalid`, `rdata[31:0]`, `err`.

## Operation
- States: IDLE, REQ, WAIT, RESP.
- **IDLE**
  - `cmd_ready_o` = 1.
  - On `cmd_valid_i & cmd_ready_o`, latch we/addr/wdata, clear the timeout counter, and go to REQ.
- **REQ**
  - `bus.req` = 1; `bus.we`, `bus.addr`, `bus.wdata` come from the latched command and are stable for the whole state.
  - `gnt` may arrive in the same cycle `req` rises.
  - On `gnt`, go to WAIT (`req` drops next cycle).
- **WAIT**
  - `bus.req` = 0.
  - On `rvalid`:
    - capture `err` into `rsp_err_o`;
    - capture `rdata` into `rsp_rdata_o` for reads, or 0 for writes;
    - go to RESP.
  - Every granted transaction, read or write, is completed by exactly one `rvalid`.
- **RESP**
  - `rsp_valid_o` = 1; data and flags are held stable until `rsp_ready_i`.
  - On handshake, go to IDLE.
- **Timeout**
  - The counter increments each cycle spent in REQ or WAIT.
  - When it reaches `TIMEOUT_CYCLES` and no `gnt` (REQ) or `rvalid` (WAIT) arrives in that cycle, go to RESP with `rsp_timeout_o`=1, `rsp_err_o`=0, `rsp_rdata_o`=0, and `req` deasserted.
  - A completion event in the same cycle as expiry wins over the timeout.
- `rvalid`, `gnt` and `err` are ignored outside REQ/WAIT. A late `rvalid` after a timeout must not create a response.
- `bus.we`, `bus.addr` and `bus.wdata` are driven to 0 whenever `bus.req` = 0.
- **Reset** (`rst_ni` low at an edge, from any state): next state is IDLE.
  - Cleared: all response registers, the latched command, and the counter.
  - `bus.req` = 0, `rsp_valid_o` = 0, `busy_o` = 0.
  - `cmd_ready_o` is gated to 0 while `rst_ni` is low and is 1 from the first cycle after release.
  - An in-flight transaction is dropped silently.

## Timing
- With a zero-wait responder (`gnt` = `req`, `rvalid` registered one cycle later):
  - accept at cycle N;
  - `req`/`gnt` at N+1;
  - `rvalid` at N+2;
  - `rsp_valid_o` at N+3.
- Back-to-back throughput is 1 transaction per 4 cycles when `rsp_ready_i` is tied high.
- `cmd_ready_o` is low from the cycle after acceptance until the cycle after the response handshake; no command overlap.
- Each additional wait cycle on `gnt` or `rvalid` adds exactly one cycle of latency.
- Timeout: with no `gnt` ever, `rsp_valid_o` rises `TIMEOUT_CYCLES` + 1 cycles after acceptance.

## Test plan
- **Reset values:** hold `rst_ni` low 3 cycles.
  - Required: `bus.req`=0, `rsp_valid_o`=0, `busy_o`=0, `cmd_ready_o`=0 during reset.
  - Required: `cmd_ready_o`=1 in the first cycle after release.
- **Write then read, zero-wait responder:** write 0x0000_0005 to 0x0, then read 0x0; responder returns 0x5.
  - Required: write response has rdata=0, err=0 at N+3.
  - Required: read response has `rsp_rdata_o`=0x0000_0005.
  - Required: `bus.addr`/`bus.wdata` stable while `req`=1.
- **Wait states:** `gnt` delayed 2 cycles and `rvalid` delayed 3 cycles; read returns 0xDEADBEEF.
  - Required: `rsp_valid_o` at N+7, rdata 0xDEADBEEF, exactly one `req`-high-with-`gnt` cycle.
- **Backpressure and error:** responder asserts `err` with `rvalid`; `rsp_ready_i` held low 5 cycles.
  - Required: `rsp_err_o`=1 and all response fields stable for 5 cycles.
  - Required: `cmd_ready_o`=0 until the cycle after the handshake.
- **Timeout:** `TIMEOUT_CYCLES`=4, no `gnt`.
  - Required: `rsp_timeout_o`=1, `rsp_valid_o` at N+5, `req` low afterwards.
  - Required: a spurious `rvalid` 2 cycles later produces no second response.
- **Reset mid-transaction:** assert `rst_ni` low in WAIT.
  - Required: IDLE next cycle, no response emitted.
  - Required: a new read after release completes normally.
